// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator: pixel-rate clock enable, sync pulses and pixel coordinates.
// Define VGA_FRAME_TICK_EN to add the frame_tick / frame_cnt outputs.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          run_q;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          tick;

  // run_q keeps p_tick low during and right after reset even when CLK_DIV is 1
  assign tick = run_q && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    // decoded from next-state counts so the registered syncs line up with pix_x/pix_y
    hsync_d = (h_cnt_d >= HS_FIRST && h_cnt_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_cnt_d >= VS_FIRST && v_cnt_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      run_q     <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
    end else begin
      div_cnt_q <= div_cnt_d;
      run_q     <= 1'b1;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign p_tick   = tick;
  assign pix_x    = h_cnt_q;
  assign pix_y    = v_cnt_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

`ifdef VGA_FRAME_TICK_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_end;

  assign frame_end = tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_tick = frame_end;
  assign frame_cnt  = frame_cnt_q;
`endif

endmodule
